// File: rtl/oven_cook_sequencer.sv
// Oven cook sequencer: accepts a temperature/time setting, preheats, runs a timed
// cook with hysteresis heater control, then holds a done indication before idling.
module oven_cook_sequencer #(
   parameter int unsigned TICK_DIV   = 50000000,
   parameter int unsigned HYST       = 5,
   parameter int unsigned DONE_TICKS = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cfg_valid,
   output logic        cfg_ready,
   input  logic [9:0]  cfg_temp,
   input  logic [12:0] cfg_time,
   input  logic        cancel,
   input  logic [9:0]  current_temp,
   output logic        heat,
   output logic        preheated,
   output logic        cooking,
   output logic [12:0] remaining_time,
   output logic        done,
   output logic [1:0]  state
);

   localparam int unsigned TW        = 10;
   localparam int unsigned MW        = 13;
   localparam int unsigned TEMP_MIN  = 65;
   localparam int unsigned TEMP_MAX  = 500;
   localparam int unsigned TEMP_RST  = 300;
   localparam int unsigned TIME_MAX  = 1800;
   localparam int unsigned TICK_LAST = (TICK_DIV > 0) ? TICK_DIV - 1 : 0;
   localparam int unsigned PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned DONE_LAST = (DONE_TICKS > 0) ? DONE_TICKS - 1 : 0;
   localparam int unsigned DCW       = (DONE_LAST > 0) ? $clog2(DONE_LAST + 1) : 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PREHEAT = 2'd1,
      COOK    = 2'd2,
      DONE    = 2'd3
   } state_e;

   state_e          state_q, state_d;
   logic [TW-1:0]   temp_q, temp_d;
   logic [MW-1:0]   time_q, time_d;
   logic [MW-1:0]   rem_q, rem_d;
   logic            heat_q, heat_d;
   logic            pre_q, pre_d;
   logic            cook_q, cook_d;
   logic            done_q, done_d;
   logic [PW-1:0]   presc_q, presc_d;
   logic [DCW-1:0]  dcnt_q, dcnt_d;

   logic            hs_c;
   logic            tick_c;
   logic [TW-1:0]   temp_clamp_c;
   logic [MW-1:0]   time_clamp_c;
   logic [TW-1:0]   thr_c;

   // Ready depends only on registered state and the cancel level.
   assign cfg_ready = (state_q == IDLE) && !cancel;
   assign hs_c      = cfg_valid && cfg_ready;
   assign tick_c    = ((state_q == COOK) || (state_q == DONE)) && (presc_q == PW'(TICK_LAST));

   always_comb begin
      temp_clamp_c = cfg_temp;
      if (cfg_temp < TW'(TEMP_MIN))
         temp_clamp_c = TW'(TEMP_MIN);
      else if (cfg_temp > TW'(TEMP_MAX))
         temp_clamp_c = TW'(TEMP_MAX);

      time_clamp_c = cfg_time;
      if (cfg_time > MW'(TIME_MAX))
         time_clamp_c = MW'(TIME_MAX);

      // Heat re-assert threshold, floored at zero.
      thr_c = '0;
      if (32'(temp_q) > HYST)
         thr_c = TW'(32'(temp_q) - HYST);
   end

   always_comb begin
      state_d = state_q;
      temp_d  = temp_q;
      time_d  = time_q;
      rem_d   = rem_q;
      heat_d  = heat_q;
      pre_d   = pre_q;
      cook_d  = cook_q;
      done_d  = done_q;
      presc_d = presc_q;
      dcnt_d  = dcnt_q;

      if (cancel && (state_q != IDLE)) begin
         state_d = IDLE;
         rem_d   = '0;
         heat_d  = 1'b0;
         pre_d   = 1'b0;
         cook_d  = 1'b0;
         done_d  = 1'b0;
         presc_d = '0;
         dcnt_d  = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (hs_c) begin
                  temp_d = temp_clamp_c;
                  time_d = time_clamp_c;
                  if (time_clamp_c != '0) begin
                     state_d = PREHEAT;
                     rem_d   = time_clamp_c;
                     heat_d  = current_temp < temp_clamp_c;
                  end
               end
            end
            PREHEAT: begin
               rem_d = time_q;
               if (current_temp >= temp_q) begin
                  state_d = COOK;
                  pre_d   = 1'b1;
                  cook_d  = 1'b1;
                  heat_d  = 1'b0;
                  presc_d = '0;
               end else begin
                  heat_d = 1'b1;
               end
            end
            COOK: begin
               presc_d = tick_c ? '0 : presc_q + PW'(1);
               if (current_temp >= temp_q)
                  heat_d = 1'b0;
               else if (current_temp < thr_c)
                  heat_d = 1'b1;
               if (tick_c) begin
                  if (rem_q <= MW'(1)) begin
                     state_d = DONE;
                     rem_d   = '0;
                     heat_d  = 1'b0;
                     pre_d   = 1'b0;
                     cook_d  = 1'b0;
                     done_d  = 1'b1;
                     presc_d = '0;
                     dcnt_d  = '0;
                  end else begin
                     rem_d = rem_q - MW'(1);
                  end
               end
            end
            DONE: begin
               presc_d = tick_c ? '0 : presc_q + PW'(1);
               if (tick_c) begin
                  if (dcnt_q == DCW'(DONE_LAST)) begin
                     state_d = IDLE;
                     done_d  = 1'b0;
                     dcnt_d  = '0;
                     presc_d = '0;
                  end else begin
                     dcnt_d = dcnt_q + DCW'(1);
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         temp_q  <= TW'(TEMP_RST);
         time_q  <= '0;
         rem_q   <= '0;
         heat_q  <= 1'b0;
         pre_q   <= 1'b0;
         cook_q  <= 1'b0;
         done_q  <= 1'b0;
         presc_q <= '0;
         dcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         temp_q  <= temp_d;
         time_q  <= time_d;
         rem_q   <= rem_d;
         heat_q  <= heat_d;
         pre_q   <= pre_d;
         cook_q  <= cook_d;
         done_q  <= done_d;
         presc_q <= presc_d;
         dcnt_q  <= dcnt_d;
      end
   end

   assign heat           = heat_q;
   assign preheated      = pre_q;
   assign cooking        = cook_q;
   assign done           = done_q;
   assign remaining_time = rem_q;
   assign state          = state_q;

endmodule

// File: tb/tb_oven_cook_sequencer.sv
// Table-driven bench for oven_cook_sequencer: per-cycle expectations go through a
// scoreboard queue; the asynchronous reset case is checked by hand.
module tb_oven_cook_sequencer;

   localparam int S_I = 0;
   localparam int S_P = 1;
   localparam int S_C = 2;
   localparam int S_D = 3;

   typedef struct packed {
      logic [1:0]  st;
      logic        heat;
      logic        pre;
      logic        cook;
      logic        done;
      logic        rdy;
      logic [12:0] rem;
   } out_t;

   typedef struct {
      logic        cancel;
      logic        valid;
      logic [9:0]  temp;
      logic [12:0] tm;
      logic [9:0]  cur;
      int          n;
      out_t        e;
   } vec_t;

   typedef struct packed {
      int   id;
      out_t e;
   } sb_t;

   logic        clk;
   logic        rst_n;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [9:0]  cfg_temp;
   logic [12:0] cfg_time;
   logic        cancel;
   logic [9:0]  current_temp;
   logic        heat;
   logic        preheated;
   logic        cooking;
   logic [12:0] remaining_time;
   logic        done;
   logic [1:0]  state;

   int   checks = 0;
   int   errors = 0;
   vec_t tbl[$];
   sb_t  sb[$];

   oven_cook_sequencer #(.TICK_DIV(4), .HYST(5), .DONE_TICKS(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_temp(cfg_temp), .cfg_time(cfg_time),
      .cancel(cancel), .current_temp(current_temp),
      .heat(heat), .preheated(preheated), .cooking(cooking),
      .remaining_time(remaining_time), .done(done), .state(state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   function automatic out_t mko(int st, bit h, bit p, bit c, bit d, bit r, int rem);
      out_t o;
      o.st   = 2'(st);
      o.heat = h;
      o.pre  = p;
      o.cook = c;
      o.done = d;
      o.rdy  = r;
      o.rem  = 13'(rem);
      return o;
   endfunction

   function automatic vec_t mkv(bit cn, bit v, int t, int tm, int cur, int n, out_t e);
      vec_t x;
      x.cancel = cn;
      x.valid  = v;
      x.temp   = 10'(t);
      x.tm     = 13'(tm);
      x.cur    = 10'(cur);
      x.n      = n;
      x.e      = e;
      return x;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Drive each row at the falling edge and queue what the next rising edge must produce.
   task automatic run_table();
      for (int r = 0; r < tbl.size(); r++) begin
         for (int k = 0; k < tbl[r].n; k++) begin
            sb_t s;
            @(negedge clk);
            cancel       = tbl[r].cancel;
            cfg_valid    = tbl[r].valid;
            cfg_temp     = tbl[r].temp;
            cfg_time     = tbl[r].tm;
            current_temp = tbl[r].cur;
            s.id = r;
            s.e  = tbl[r].e;
            sb.push_back(s);
         end
      end
      for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d expectations never compared", sb.size());
         sb.delete();
      end
      tbl.delete();
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() != 0) begin
            sb_t  s;
            out_t a;
            s = sb.pop_front();
            a = {state, heat, preheated, cooking, done, cfg_ready, remaining_time};
            checks++;
            if (a !== s.e) begin
               errors++;
               $display("FAIL row%0d: got st=%0d heat=%0b pre=%0b cook=%0b done=%0b rdy=%0b rem=%0d expected st=%0d heat=%0b pre=%0b cook=%0b done=%0b rdy=%0b rem=%0d",
                        s.id, a.st, a.heat, a.pre, a.cook, a.done, a.rdy, a.rem,
                        s.e.st, s.e.heat, s.e.pre, s.e.cook, s.e.done, s.e.rdy, s.e.rem);
            end
         end
      end
   end

   initial begin
      rst_n        = 1'b0;
      cfg_valid    = 1'b0;
      cfg_temp     = '0;
      cfg_time     = '0;
      cancel       = 1'b0;
      current_temp = '0;
      #1;
      chk("reset_state", int'(state), S_I);
      chk("reset_outputs", int'({heat, preheated, cooking, done}), 0);
      chk("reset_remaining", int'(remaining_time), 0);
      chk("reset_ready", int'(cfg_ready), 1);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Basic cook: preheat ramp, 4-cycle ticks, DONE held for 2 ticks.
      tbl.push_back(mkv(0, 1, 350, 3, 300, 1, mko(S_P, 1, 0, 0, 0, 0, 3)));
      tbl.push_back(mkv(0, 0, 0, 0, 320, 2, mko(S_P, 1, 0, 0, 0, 0, 3)));
      tbl.push_back(mkv(0, 0, 0, 0, 350, 4, mko(S_C, 0, 1, 1, 0, 0, 3)));
      tbl.push_back(mkv(0, 0, 0, 0, 350, 4, mko(S_C, 0, 1, 1, 0, 0, 2)));
      tbl.push_back(mkv(0, 0, 0, 0, 350, 4, mko(S_C, 0, 1, 1, 0, 0, 1)));
      tbl.push_back(mkv(0, 0, 0, 0, 350, 8, mko(S_D, 0, 0, 0, 1, 0, 0)));
      tbl.push_back(mkv(0, 0, 0, 0, 350, 1, mko(S_I, 0, 0, 0, 0, 1, 0)));
      // Hysteresis at 350, then cancel with 2 s left, then cancel masking a handshake.
      tbl.push_back(mkv(0, 1, 350, 3, 350, 1, mko(S_P, 0, 0, 0, 0, 0, 3)));
      tbl.push_back(mkv(0, 0, 0, 0, 350, 1, mko(S_C, 0, 1, 1, 0, 0, 3)));
      tbl.push_back(mkv(0, 0, 0, 0, 346, 2, mko(S_C, 0, 1, 1, 0, 0, 3)));
      tbl.push_back(mkv(0, 0, 0, 0, 344, 1, mko(S_C, 1, 1, 1, 0, 0, 3)));
      tbl.push_back(mkv(0, 0, 0, 0, 349, 1, mko(S_C, 1, 1, 1, 0, 0, 2)));
      tbl.push_back(mkv(0, 0, 0, 0, 350, 1, mko(S_C, 0, 1, 1, 0, 0, 2)));
      tbl.push_back(mkv(1, 0, 0, 0, 350, 1, mko(S_I, 0, 0, 0, 0, 0, 0)));
      tbl.push_back(mkv(1, 1, 100, 10, 350, 2, mko(S_I, 0, 0, 0, 0, 0, 0)));
      tbl.push_back(mkv(0, 0, 0, 0, 350, 1, mko(S_I, 0, 0, 0, 0, 1, 0)));
      // Clamping: high limits, low temperature limit, zero time.
      tbl.push_back(mkv(0, 1, 600, 2000, 400, 1, mko(S_P, 1, 0, 0, 0, 0, 1800)));
      tbl.push_back(mkv(0, 0, 0, 0, 499, 2, mko(S_P, 1, 0, 0, 0, 0, 1800)));
      tbl.push_back(mkv(0, 0, 0, 0, 500, 1, mko(S_C, 0, 1, 1, 0, 0, 1800)));
      tbl.push_back(mkv(1, 0, 0, 0, 500, 1, mko(S_I, 0, 0, 0, 0, 0, 0)));
      tbl.push_back(mkv(0, 1, 20, 5, 0, 1, mko(S_P, 1, 0, 0, 0, 0, 5)));
      tbl.push_back(mkv(0, 0, 0, 0, 64, 1, mko(S_P, 1, 0, 0, 0, 0, 5)));
      tbl.push_back(mkv(0, 0, 0, 0, 65, 1, mko(S_C, 0, 1, 1, 0, 0, 5)));
      tbl.push_back(mkv(1, 0, 0, 0, 65, 1, mko(S_I, 0, 0, 0, 0, 0, 0)));
      tbl.push_back(mkv(0, 1, 200, 0, 0, 1, mko(S_I, 0, 0, 0, 0, 1, 0)));
      tbl.push_back(mkv(0, 0, 0, 0, 0, 2, mko(S_I, 0, 0, 0, 0, 1, 0)));
      // Offers outside IDLE leave the latched 350/4 untouched.
      tbl.push_back(mkv(0, 1, 350, 4, 300, 1, mko(S_P, 1, 0, 0, 0, 0, 4)));
      tbl.push_back(mkv(0, 1, 100, 50, 300, 2, mko(S_P, 1, 0, 0, 0, 0, 4)));
      tbl.push_back(mkv(0, 1, 100, 50, 350, 1, mko(S_C, 0, 1, 1, 0, 0, 4)));
      tbl.push_back(mkv(0, 0, 0, 0, 350, 2, mko(S_C, 0, 1, 1, 0, 0, 4)));
      run_table();

      // Asynchronous reset between edges while cooking.
      chk("precondition_cook", int'(state), S_C);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_state", int'(state), S_I);
      chk("async_flags", int'({heat, preheated, cooking, done}), 0);
      chk("async_remaining", int'(remaining_time), 0);
      chk("async_ready", int'(cfg_ready), 1);
      cancel = 1'b1;
      #1;
      chk("reset_ready_cancel", int'(cfg_ready), 0);
      cancel = 1'b0;
      rst_n  = 1'b1;

      tbl.push_back(mkv(0, 0, 0, 0, 350, 3, mko(S_I, 0, 0, 0, 0, 1, 0)));
      tbl.push_back(mkv(0, 1, 400, 2, 350, 1, mko(S_P, 1, 0, 0, 0, 0, 2)));
      tbl.push_back(mkv(0, 0, 0, 0, 400, 1, mko(S_C, 0, 1, 1, 0, 0, 2)));
      run_table();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
